lz77_token_packer: RTL and testbench

Downstream stage of the LZ77 encoder. It captures each (match_position, match_length, next_symbol) triplet the encoder qualifies with output_enable and encodes it as a variable-length token: a literal when length is 0, otherwise a match. Tokens are buffered in a small FIFO and packed MSB-first into fixed-width words. Words leave on a valid/ready stream toward the entropy/serializer stage. A flush command pads and terminates the stream at block end.

---
 rtl/lz77_token_packer_if.sv | 30 +++
 rtl/lz77_token_packer.sv | 128 ++++++++++++
 tb/tb_lz77_token_packer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lz77_token_packer_if.sv
// Handshake and status bundle between the LZ77 encoder, the token packer and the serializer.
interface lz77_token_packer_if #(
  parameter int DATA_WIDTH           = 8,
  parameter int DICTIONARY_DEPTH_LOG = 4,
  parameter int CNT_WIDTH            = 3,
  parameter int OUT_WIDTH            = 16
);
  logic                            in_valid;
  logic [DICTIONARY_DEPTH_LOG-1:0] match_position;
  logic [CNT_WIDTH-1:0]            match_length;
  logic [DATA_WIDTH-1:0]           next_symbol;
  logic                            in_ready;
  logic                            flush;
  logic [OUT_WIDTH-1:0]            out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic                            flush_done;
  logic                            overflow;

  modport master (
    output in_valid, match_position, match_length, next_symbol, flush, out_ready,
    input  in_ready, out_data, out_valid, out_last, flush_done, overflow
  );

  modport slave (
    input  in_valid, match_position, match_length, next_symbol, flush, out_ready,
    output in_ready, out_data, out_valid, out_last, flush_done, overflow
  );
endinterface

// File: rtl/lz77_token_packer.sv
// Encodes LZ77 triplets as literal/match tokens, buffers them and packs them MSB-first
// into fixed-width words; a flush pads the tail word and signals completion.
module lz77_token_packer #(
  parameter int DATA_WIDTH           = 8,
  parameter int DICTIONARY_DEPTH_LOG = 4,
  parameter int CNT_WIDTH            = 3,
  parameter int OUT_WIDTH            = 16,
  parameter int FIFO_DEPTH           = 4,
  parameter int FIFO_DEPTH_LOG       = 2
) (
  input logic                clk,
  input logic                rst_n,
  lz77_token_packer_if.slave bus
);
  localparam int LIT_LEN = 1 + DATA_WIDTH;
  localparam int MAT_LEN = 1 + DICTIONARY_DEPTH_LOG + CNT_WIDTH + DATA_WIDTH;
  localparam int ACC_W   = OUT_WIDTH + 16 - 1;
  localparam int ACW     = $clog2(ACC_W + 1);
  localparam int PW      = FIFO_DEPTH_LOG + 1;

  typedef struct packed {
    logic [DICTIONARY_DEPTH_LOG-1:0] pos;
    logic [CNT_WIDTH-1:0]            len;
    logic [DATA_WIDTH-1:0]           sym;
  } tok_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PAD, S_DONE} state_t;

  state_t           state_q, state_d;
  tok_t             mem_q [FIFO_DEPTH];
  tok_t             mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACW-1:0]   acc_cnt_q, acc_cnt_d;
  logic             overflow_q, overflow_d;

  logic             fifo_empty, fifo_full, wr_en, pop, emit, word_full;
  tok_t             head;
  logic [ACW-1:0]   tok_len, shift;
  logic [ACC_W-1:0] tok_bits;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign word_full  = (acc_cnt_q >= ACW'(OUT_WIDTH));

  // Full is taken from the registered pointers, so a same-cycle pop never frees a slot early.
  assign bus.in_ready   = !fifo_full && (state_q == S_RUN);
  assign bus.out_valid  = word_full || (state_q == S_PAD);
  assign bus.out_last   = (state_q == S_PAD);
  assign bus.flush_done = (state_q == S_DONE);
  assign bus.out_data   = acc_q[ACC_W-1 -: OUT_WIDTH];
  assign bus.overflow   = overflow_q;

  assign wr_en = bus.in_valid && bus.in_ready;
  assign pop   = !fifo_empty && !word_full && (state_q != S_PAD);
  assign emit  = bus.out_valid && bus.out_ready;

  assign head     = mem_q[rd_ptr_q[PW-2:0]];
  assign tok_len  = (head.len == '0) ? ACW'(LIT_LEN) : ACW'(MAT_LEN);
  assign tok_bits = (head.len == '0) ? ACC_W'({1'b0, head.sym})
                                     : ACC_W'({1'b1, head.pos, head.len, head.sym});
  assign shift    = ACW'(ACC_W) - acc_cnt_q - tok_len;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    overflow_d = overflow_q || (bus.in_valid && !bus.in_ready);

    if (wr_en) begin
      mem_d[wr_ptr_q[PW-2:0]] = '{pos: bus.match_position,
                                  len: bus.match_length,
                                  sym: bus.next_symbol};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // pop needs acc_cnt < OUT_WIDTH, emit needs >= (or PAD), so they are exclusive.
    if (pop) begin
      acc_d     = acc_q | (tok_bits << shift);
      acc_cnt_d = acc_cnt_q + tok_len;
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end else if (emit) begin
      if (state_q == S_PAD) begin
        acc_d     = '0;
        acc_cnt_d = '0;
      end else begin
        acc_d     = acc_q << OUT_WIDTH;
        acc_cnt_d = acc_cnt_q - ACW'(OUT_WIDTH);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (bus.flush) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty && !word_full)
                 state_d = (acc_cnt_q != '0) ? S_PAD : S_DONE;
      S_PAD:   if (bus.out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_lz77_token_packer.sv
// Directed-vector and reference-stream bench for lz77_token_packer.
module tb_lz77_token_packer;
  logic clk;
  logic rst_n;

  lz77_token_packer_if #(.DATA_WIDTH(8), .DICTIONARY_DEPTH_LOG(4),
                         .CNT_WIDTH(3), .OUT_WIDTH(16)) bus ();

  lz77_token_packer #(.DATA_WIDTH(8), .DICTIONARY_DEPTH_LOG(4), .CNT_WIDTH(3),
                      .OUT_WIDTH(16), .FIFO_DEPTH(4), .FIFO_DEPTH_LOG(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] got_words[$];
  bit          got_last[$];
  bit          exp_bits[$];
  int          n_fd  = 0;
  int          n_acc = 0;

  typedef struct {
    bit          flush_case;
    logic [3:0]  pos;
    logic [2:0]  len;
    logic [7:0]  sym;
    logic [15:0] word;
    bit          last;
  } vec_t;

  vec_t vecs[8];

  // Output/input monitor: records accepted words and the reference token bitstream.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        got_words.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
      end
      if (bus.in_valid && bus.in_ready) begin
        n_acc++;
        if (bus.match_length == 3'd0) begin
          exp_bits.push_back(1'b0);
        end else begin
          exp_bits.push_back(1'b1);
          for (int i = 3; i >= 0; i--) exp_bits.push_back(bus.match_position[i]);
          for (int i = 2; i >= 0; i--) exp_bits.push_back(bus.match_length[i]);
        end
        for (int i = 7; i >= 0; i--) exp_bits.push_back(bus.next_symbol[i]);
      end
      if (bus.flush_done) n_fd++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_words.delete();
    got_last.delete();
    exp_bits.delete();
  endtask

  task automatic drive_tok(input logic [3:0] pos, input logic [2:0] len, input logic [7:0] sym);
    bus.in_valid       = 1'b1;
    bus.match_position = pos;
    bus.match_length   = len;
    bus.next_symbol    = sym;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int t = 0;
    while (got_words.size() < n && t < budget) begin
      cyc();
      t++;
    end
    if (got_words.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d words expected %0d", tag, got_words.size(), n);
    end
  endtask

  task automatic wait_fd(input int target, input int budget, input bit rand_ready, input string tag);
    int t = 0;
    while (n_fd < target && t < budget) begin
      if (rand_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
      cyc();
      t++;
    end
    if (n_fd < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: flush_done count %0d expected %0d", tag, n_fd, target);
    end
  endtask

  task automatic check_stream(input string tag);
    int          rem;
    int          nw;
    logic [15:0] w;
    rem = exp_bits.size() % 16;
    while (exp_bits.size() % 16 != 0) exp_bits.push_back(1'b0);
    nw = exp_bits.size() / 16;
    chk({tag, "_nwords"}, got_words.size(), nw);
    for (int k = 0; k < nw && k < got_words.size(); k++) begin
      for (int b = 0; b < 16; b++) w[15-b] = exp_bits[k*16+b];
      chk($sformatf("%s_word%0d", tag, k), got_words[k], w);
      chk($sformatf("%s_last%0d", tag, k), got_last[k], (k == nw-1) && (rem != 0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"},  bus.out_valid,  1'b0);
    chk({tag, "_out_data"},   bus.out_data,   16'h0000);
    chk({tag, "_out_last"},   bus.out_last,   1'b0);
    chk({tag, "_flush_done"}, bus.flush_done, 1'b0);
    chk({tag, "_overflow"},   bus.overflow,   1'b0);
    chk({tag, "_in_ready"},   bus.in_ready,   1'b1);
  endtask

  initial begin
    int fd0;
    int acc0;

    vecs[0] = '{0, 4'h3, 3'd2, 8'h42, 16'h9A42, 0};
    vecs[1] = '{0, 4'hF, 3'd7, 8'hFF, 16'hFFFF, 0};
    vecs[2] = '{0, 4'h0, 3'd1, 8'h00, 16'h8100, 0};
    vecs[3] = '{0, 4'hA, 3'd5, 8'h3C, 16'hD53C, 0};
    vecs[4] = '{1, 4'h0, 3'd0, 8'h41, 16'h2080, 1};
    vecs[5] = '{1, 4'h5, 3'd0, 8'hFF, 16'h7F80, 1};
    vecs[6] = '{1, 4'h0, 3'd0, 8'h00, 16'h0000, 1};
    vecs[7] = '{1, 4'hC, 3'd0, 8'h81, 16'h4080, 1};

    rst_n              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.match_position = '0;
    bus.match_length   = '0;
    bus.next_symbol    = '0;
    bus.flush          = 1'b0;
    bus.out_ready      = 1'b0;

    #12;
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("rst_in_ready_after", bus.in_ready, 1'b1);

    // Latency: written at edge N, word visible after edge N+1.
    clear_q();
    drive_tok(4'h3, 3'd2, 8'h42);
    chk("lat_valid_n", bus.out_valid, 1'b0);
    cyc();
    chk("lat_valid_n1", bus.out_valid, 1'b1);
    chk("lat_data", bus.out_data, 16'h9A42);
    cyc();
    chk("lat_stall_data", bus.out_data, 16'h9A42);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("lat_nwords", got_words.size(), 1);
    chk("lat_drained", bus.out_valid, 1'b0);

    // Table-driven single-token vectors.
    for (int v = 0; v < 8; v++) begin
      clear_q();
      fd0 = n_fd;
      bus.out_ready = 1'b1;
      drive_tok(vecs[v].pos, vecs[v].len, vecs[v].sym);
      if (vecs[v].flush_case) pulse_flush();
      wait_words(1, 30, $sformatf("vec%0d", v));
      if (vecs[v].flush_case) wait_fd(fd0 + 1, 30, 0, $sformatf("vec%0d_fd", v));
      repeat (4) cyc();
      chk($sformatf("vec%0d_nwords", v), got_words.size(), 1);
      if (got_words.size() > 0) begin
        chk($sformatf("vec%0d_word", v), got_words[0], vecs[v].word);
        chk($sformatf("vec%0d_last", v), got_last[0], vecs[v].last);
      end
      chk($sformatf("vec%0d_fd", v), n_fd - fd0, vecs[v].flush_case ? 1 : 0);
    end

    // Two literals then flush: full word, padded last word, done pulse.
    clear_q();
    fd0 = n_fd;
    bus.out_ready = 1'b1;
    drive_tok(4'h0, 3'd0, 8'h41);
    drive_tok(4'h0, 3'd0, 8'h42);
    pulse_flush();
    wait_fd(fd0 + 1, 40, 0, "two_lit");
    repeat (3) cyc();
    chk("two_lit_nwords", got_words.size(), 2);
    if (got_words.size() == 2) begin
      chk("two_lit_w0", got_words[0], 16'h2090);
      chk("two_lit_l0", got_last[0], 1'b0);
      chk("two_lit_w1", got_words[1], 16'h8000);
      chk("two_lit_l1", got_last[1], 1'b1);
    end
    chk("two_lit_fd", n_fd - fd0, 1);

    // Flush with nothing pending: done pulse only.
    clear_q();
    fd0 = n_fd;
    pulse_flush();
    wait_fd(fd0 + 1, 20, 0, "empty_flush");
    repeat (4) cyc();
    chk("empty_flush_nwords", got_words.size(), 0);
    chk("empty_flush_fd", n_fd - fd0, 1);

    // Stalled output with continuous literals: 6 accepted, rest dropped.
    clear_q();
    acc0 = n_acc;
    bus.out_ready      = 1'b0;
    bus.in_valid       = 1'b1;
    bus.match_position = 4'h0;
    bus.match_length   = 3'd0;
    bus.next_symbol    = 8'h41;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i >= 2 && (i % 2 == 0)) begin
        chk($sformatf("ovf_valid%0d", i), bus.out_valid, 1'b1);
        chk($sformatf("ovf_data%0d", i), bus.out_data, 16'h2090);
      end
    end
    bus.in_valid = 1'b0;
    chk("ovf_accepted", n_acc - acc0, 6);
    chk("ovf_flag", bus.overflow, 1'b1);
    fd0 = n_fd;
    bus.out_ready = 1'b1;
    pulse_flush();
    wait_fd(fd0 + 1, 100, 0, "ovf_drain");
    cyc();
    chk("ovf_sticky", bus.overflow, 1'b1);
    check_stream("ovf");

    // Random triplets with random stalls against the reference bitstream.
    clear_q();
    for (int i = 0; i < 60; i++) begin
      bus.in_valid       = ($urandom_range(0, 1) == 1);
      bus.match_position = 4'($urandom_range(0, 15));
      bus.match_length   = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.next_symbol    = 8'($urandom_range(0, 255));
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.in_valid = 1'b0;
    fd0 = n_fd;
    pulse_flush();
    wait_fd(fd0 + 1, 600, 1, "rand");
    bus.out_ready = 1'b1;
    repeat (2) cyc();
    check_stream("rand");

    // Reset asserted while draining with FIFO content pending.
    clear_q();
    bus.out_ready      = 1'b0;
    bus.in_valid       = 1'b1;
    bus.match_length   = 3'd0;
    bus.next_symbol    = 8'h55;
    repeat (6) cyc();
    bus.in_valid = 1'b0;
    pulse_flush();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_drain");
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    bus.out_ready = 1'b1;
    drive_tok(4'h3, 3'd2, 8'h42);
    wait_words(1, 20, "post_rst");
    repeat (3) cyc();
    chk("post_rst_nwords", got_words.size(), 1);
    if (got_words.size() > 0) begin
      chk("post_rst_word", got_words[0], 16'h9A42);
      chk("post_rst_last", got_last[0], 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
